// File: rtl/nios2_c_cpu_jtag_debug_cmd_sync.sv
// Sysclk-side JTAG debug command bridge: synchronises update-IR/DR toggles from tck,
// captures the scanned DR and issues one action pulse per IR channel with ack/overrun tracking.
module nios2_c_cpu_jtag_debug_cmd_sync #(
   parameter int unsigned IR_WIDTH                 = 2,
   parameter int unsigned DR_WIDTH                 = 38,
   parameter int unsigned ACTION_BIT               = 35,
   parameter int unsigned SYNC_STAGES              = 2,
   parameter logic [(2**IR_WIDTH)-1:0] ACK_MASK    = '0,
   parameter int unsigned ACK_TIMEOUT              = 255,
   parameter int unsigned CNT_WIDTH                = 8,
   localparam int unsigned NUM_CH                  = 2**IR_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [IR_WIDTH-1:0]  ir_in,
   input  logic [DR_WIDTH-1:0]  sr,
   input  logic                 vs_uir_tgl,
   input  logic                 vs_udr_tgl,
   input  logic                 cmd_done,
   input  logic                 clr_overrun,
   output logic [DR_WIDTH-1:0]  jdo,
   output logic [NUM_CH-1:0]    take_action,
   output logic [NUM_CH-1:0]    take_no_action,
   output logic [IR_WIDTH-1:0]  ir_latched,
   output logic                 cmd_busy,
   output logic                 overrun,
   output logic [CNT_WIDTH-1:0] overrun_cnt,
   output logic                 ack_timeout
);

   localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
   logic                   uir_edge_q, udr_edge_q;
   logic                   uir_ev, udr_ev;
   logic [DR_WIDTH-1:0]    jdo_q, jdo_d;
   logic [IR_WIDTH-1:0]    ch_q, ch_d;
   logic [IR_WIDTH-1:0]    ir_q, ir_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [NUM_CH-1:0]      ta_q, ta_d, tna_q, tna_d;
   logic                   busy_q, busy_d;
   logic                   ov_q, ov_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ato_q, ato_d;

   assign uir_ev = uir_sync_q[SYNC_STAGES-1] ^ uir_edge_q;
   assign udr_ev = udr_sync_q[SYNC_STAGES-1] ^ udr_edge_q;

   always_comb begin
      state_d = state_q;
      jdo_d   = jdo_q;
      ch_d    = ch_q;
      timer_d = timer_q;
      ta_d    = '0;
      tna_d   = '0;
      ov_d    = ov_q;
      cnt_d   = cnt_q;
      ato_d   = ato_q;
      // A same-cycle update-IR is visible to the update-DR decode below.
      ir_d    = uir_ev ? ir_in : ir_q;

      if (clr_overrun) begin
         ov_d  = 1'b0;
         cnt_d = '0;
         ato_d = 1'b0;
      end
      // Overrun evaluated after the clear so a coincident new overrun wins.
      if (udr_ev && (state_q != StIdle)) begin
         ov_d = 1'b1;
         if (cnt_d != '1) cnt_d = cnt_d + CNT_WIDTH'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (udr_ev) begin
               jdo_d   = sr;
               ch_d    = ir_d;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (jdo_q[ACTION_BIT]) ta_d[ch_q]  = 1'b1;
            else                   tna_d[ch_q] = 1'b1;
            timer_d = '0;
            state_d = ACK_MASK[ch_q] ? StWaitAck : StIdle;
         end
         StWaitAck: begin
            if (cmd_done) begin
               state_d = StIdle;
            end else if (timer_q == TIMER_LAST) begin
               state_d = StIdle;
               ato_d   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync_q <= '0;
         udr_sync_q <= '0;
         uir_edge_q <= 1'b0;
         udr_edge_q <= 1'b0;
         state_q    <= StIdle;
         jdo_q      <= '0;
         ch_q       <= '0;
         ir_q       <= '0;
         timer_q    <= '0;
         ta_q       <= '0;
         tna_q      <= '0;
         busy_q     <= 1'b0;
         ov_q       <= 1'b0;
         cnt_q      <= '0;
         ato_q      <= 1'b0;
      end else begin
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_tgl};
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_tgl};
         uir_edge_q <= uir_sync_q[SYNC_STAGES-1];
         udr_edge_q <= udr_sync_q[SYNC_STAGES-1];
         state_q    <= state_d;
         jdo_q      <= jdo_d;
         ch_q       <= ch_d;
         ir_q       <= ir_d;
         timer_q    <= timer_d;
         ta_q       <= ta_d;
         tna_q      <= tna_d;
         busy_q     <= busy_d;
         ov_q       <= ov_d;
         cnt_q      <= cnt_d;
         ato_q      <= ato_d;
      end
   end

   assign jdo            = jdo_q;
   assign take_action    = ta_q;
   assign take_no_action = tna_q;
   assign ir_latched     = ir_q;
   assign cmd_busy       = busy_q;
   assign overrun        = ov_q;
   assign overrun_cnt    = cnt_q;
   assign ack_timeout    = ato_q;

endmodule

// File: tb/tb_nios2_c_cpu_jtag_debug_cmd_sync.sv
// Directed bench for the JTAG debug command bridge; expected pulses are queued when a
// command is driven and popped by a monitor whenever the DUT pulses an action output.
module tb_nios2_c_cpu_jtag_debug_cmd_sync;

   localparam int unsigned ACK_TO = 30;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_uir_tgl, vs_udr_tgl, cmd_done, clr_overrun;
   logic [37:0] jdo;
   logic [3:0]  take_action, take_no_action;
   logic [1:0]  ir_latched;
   logic        cmd_busy, overrun, ack_timeout;
   logic [1:0]  overrun_cnt;

   typedef struct {
      logic [3:0]  ta;
      logic [3:0]  tna;
      logic [37:0] jdo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   nios2_c_cpu_jtag_debug_cmd_sync #(
      .IR_WIDTH    (2),
      .DR_WIDTH    (38),
      .ACTION_BIT  (35),
      .SYNC_STAGES (2),
      .ACK_MASK    (4'b0001),
      .ACK_TIMEOUT (ACK_TO),
      .CNT_WIDTH   (2)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ir_in          (ir_in),
      .sr             (sr),
      .vs_uir_tgl     (vs_uir_tgl),
      .vs_udr_tgl     (vs_udr_tgl),
      .cmd_done       (cmd_done),
      .clr_overrun    (clr_overrun),
      .jdo            (jdo),
      .take_action    (take_action),
      .take_no_action (take_no_action),
      .ir_latched     (ir_latched),
      .cmd_busy       (cmd_busy),
      .overrun        (overrun),
      .overrun_cnt    (overrun_cnt),
      .ack_timeout    (ack_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [1:0] ch, input logic [37:0] val);
      exp_t e;
      e.jdo = val;
      e.ta  = val[35] ? (4'b0001 << ch) : 4'b0000;
      e.tna = val[35] ? 4'b0000 : (4'b0001 << ch);
      sb.push_back(e);
   endtask

   task automatic send_ir(input logic [1:0] ir);
      ir_in      = ir;
      vs_uir_tgl = ~vs_uir_tgl;
      tick(4);
   endtask

   task automatic cmd(input logic [1:0] ir, input logic [37:0] val);
      send_ir(ir);
      sr         = val;
      vs_udr_tgl = ~vs_udr_tgl;
      push(ir, val);
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (!cmd_busy && n < 20) begin
         tick(1);
         n++;
      end
      check(tag, 64'(cmd_busy), 64'd1);
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick(1);
         n++;
      end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic ack();
      cmd_done = 1'b1;
      tick(1);
      cmd_done = 1'b0;
   endtask

   task automatic clear();
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
   endtask

   // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
   always @(posedge clk) begin
      #1;
      if (reset_n && (take_action != 4'b0 || take_no_action != 4'b0)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {take_action, take_no_action}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse", {jdo, take_action, take_no_action}, {e.jdo, e.ta, e.tna});
         end
      end
   end

   initial begin
      int n;
      reset_n     = 1'b0;
      ir_in       = 2'd0;
      sr          = '0;
      vs_uir_tgl  = 1'b0;
      vs_udr_tgl  = 1'b0;
      cmd_done    = 1'b0;
      clr_overrun = 1'b0;
      tick(3);
      check("rst_jdo", jdo, 0);
      check("rst_pulses", {take_action, take_no_action}, 0);
      check("rst_flags", {ir_latched, cmd_busy, overrun, overrun_cnt, ack_timeout}, 0);
      reset_n = 1'b1;
      tick(3);
      check("idle_no_event", {take_action, take_no_action, cmd_busy}, 0);

      // Action on channel 2 with exact latency
      send_ir(2'd2);
      check("ir_latched_2", ir_latched, 2'd2);
      sr         = 38'hA_DEAD_BEEF;
      vs_udr_tgl = ~vs_udr_tgl;
      push(2'd2, 38'hA_DEAD_BEEF);
      tick(3);
      check("pulse_not_early", take_action, 4'b0000);
      tick(1);
      check("take_action_ch2", take_action, 4'b0100);
      check("jdo_ch2", jdo, 38'hA_DEAD_BEEF);
      tick(1);
      check("pulse_one_cycle", take_action, 4'b0000);
      drain("drain_1");

      // No-action on channel 1
      cmd(2'd1, 38'h0_1234_5678);
      tick(6);
      drain("drain_2");
      check("busy_after_ch1", cmd_busy, 1'b0);

      // Channel 0 waits for ack: let it time out
      cmd(2'd0, 38'h8_0000_0001);
      wait_busy("busy_rise_to");
      n = 0;
      while (cmd_busy && n < 200) begin
         if (n == 5) check("no_timeout_yet", ack_timeout, 1'b0);
         tick(1);
         n++;
      end
      check("busy_len", 64'(n >= ACK_TO && n <= ACK_TO + 1), 64'd1);
      check("ack_timeout_set", ack_timeout, 1'b1);
      clear();
      check("ack_timeout_clr", ack_timeout, 1'b0);

      // Channel 0 acked at cycle 10
      cmd(2'd0, 38'h8_0000_0002);
      wait_busy("busy_rise_ack");
      tick(10);
      ack();
      check("idle_after_ack", cmd_busy, 1'b0);
      tick(2);
      check("no_timeout_on_ack", ack_timeout, 1'b0);

      // Three overruns during WAIT_ACK
      cmd(2'd0, 38'h8_0000_0003);
      wait_busy("busy_rise_ov");
      for (int i = 1; i <= 3; i++) begin
         sr         = 38'h1_1111_1111 * i;
         vs_udr_tgl = ~vs_udr_tgl;
         tick(3);
      end
      tick(2);
      check("overrun_set", overrun, 1'b1);
      check("overrun_cnt_3", overrun_cnt, 2'd3);
      check("jdo_kept", jdo, 38'h8_0000_0003);
      ack();
      clear();
      check("overrun_clr", {overrun, overrun_cnt, ack_timeout}, 0);

      // Five overruns saturate the 2-bit counter
      cmd(2'd0, 38'h8_0000_0004);
      wait_busy("busy_rise_sat");
      for (int i = 0; i < 5; i++) begin
         vs_udr_tgl = ~vs_udr_tgl;
         tick(3);
      end
      tick(2);
      check("overrun_cnt_sat", overrun_cnt, 2'd3);
      ack();
      clear();
      drain("drain_3");

      // Simultaneous update-IR and update-DR: new IR decodes
      ir_in      = 2'd3;
      sr         = 38'h8_0000_00AA;
      vs_uir_tgl = ~vs_uir_tgl;
      vs_udr_tgl = ~vs_udr_tgl;
      push(2'd3, 38'h8_0000_00AA);
      tick(6);
      check("ir_latched_same", ir_latched, 2'd3);
      drain("drain_same");

      // Reset while in ISSUE: pulse lost, then toggles held high give one event each
      send_ir(2'd2);
      sr         = 38'h8_0000_00BB;
      vs_udr_tgl = ~vs_udr_tgl;
      tick(3);
      check("busy_in_issue", cmd_busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", {jdo, take_action, take_no_action, cmd_busy}, 0);
      ir_in      = 2'd3;
      sr         = 38'h0_0000_00CC;
      vs_uir_tgl = 1'b1;
      vs_udr_tgl = 1'b1;
      tick(3);
      check("rst_mid_flags", {ir_latched, overrun, overrun_cnt, ack_timeout}, 0);
      push(2'd3, 38'h0_0000_00CC);
      reset_n = 1'b1;
      tick(8);
      drain("drain_post_reset");
      check("ir_after_reset", ir_latched, 2'd3);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
